// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID boundary: fetch packet, NOP word and
// the skid occupancy states seen from (main_valid, skid_valid).
package if_id_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;
  localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_pkt_t;

  // Encoding is {skid_valid, main_valid}; 2'b10 is the unreachable combination.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/if_id_skid_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment);
// shared by the per-stage performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a 2-entry skid buffer: in_ready comes straight
// from the skid flop, so decode back-pressure never reaches fetch combinationally.
module if_id_skid
  import if_id_pkg::*;
#(
  parameter int                 PC_W     = PC_W_DEF,
  parameter int                 INST_W   = INST_W_DEF,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEF),
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]   main_pc_q, skid_pc_q;
  logic [INST_W-1:0] main_inst_q, skid_inst_q;

  logic in_fire;
  logic out_fire;
  logic main_ld_in;
  logic main_ld_skid;
  logic skid_ld;

  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & ~skid_valid_q;
  assign out_fire = main_valid_q & out_ready;

  // Occupancy control; flush overrides every transition and discards in_fire.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (in_fire) begin
        main_valid_d = 1'b1;
        main_ld_in   = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (in_fire && out_fire) begin
        main_ld_in = 1'b1;
      end else if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_ld      = 1'b1;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
      end
    end else if (out_fire) begin
      main_ld_skid = 1'b1;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Data flops only move on their own load enable, so out_pc holds while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pc_q   <= '0;
      main_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      if (main_ld_in) begin
        main_pc_q   <= in_pc;
        main_inst_q <= in_inst;
      end else if (main_ld_skid) begin
        main_pc_q   <= skid_pc_q;
        main_inst_q <= skid_inst_q;
      end
      if (skid_ld) begin
        skid_pc_q   <= in_pc;
        skid_inst_q <= in_inst;
      end
    end
  end

  assign out_valid = main_valid_q;
  assign out_pc    = main_pc_q;
  assign out_inst  = main_valid_q ? main_inst_q : NOP_INST;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (main_valid_q & ~out_ready),
    .clr_i   (clr_cnt),
    .count_o (stall_cnt)
  );

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed scenarios plus random traffic, scored against
// a 2-deep FIFO reference model and a saturating counter model.
module tb_if_id_skid;
  import if_id_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;
  logic        clr_cnt = 1'b0;

  if_id_skid #(
    .PC_W     (32),
    .INST_W   (32),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .clr_cnt   (clr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: entries currently held, in FIFO order.
  fetch_pkt_t  exp_q[$];
  int          exp_cnt = 0;
  logic [31:0] exp_last_pc = '0;

  // Effects of the cycle just driven, retired after the next rising edge.
  logic       p_push = 1'b0;
  logic       p_flush = 1'b0;
  logic       p_clr = 1'b0;
  logic       p_stall = 1'b0;
  fetch_pkt_t p_pkt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl, input logic cl);
    @(posedge clk);
    #1;
    if (p_flush) exp_q.delete();
    else if (p_push) exp_q.push_back(p_pkt);
    if (p_clr) exp_cnt = 0;
    else if (p_stall && exp_cnt < CNT_MAX) exp_cnt++;
    if (exp_q.size() > 0) exp_last_pc = exp_q[0].pc;

    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = cl;

    p_push  = iv && (exp_q.size() < 2) && !fl;
    p_flush = fl;
    p_clr   = cl;
    p_stall = (exp_q.size() > 0) && !ordy;
    p_pkt   = '{pc: pc, inst: inst};
  endtask

  // Monitor: compare DUT outputs against the model and consume on out_fire.
  int          mon_sz;
  logic [1:0]  dut_st;
  skid_state_e exp_st;
  always @(negedge clk) begin
    if (rst) begin
      mon_sz = exp_q.size();
      exp_st = (mon_sz == 0) ? EMPTY : ((mon_sz == 1) ? ONE : FULL);
      dut_st = {~in_ready, out_valid};
      chk("illegal_state", 64'(dut_st == 2'b10), 64'd0);
      chk("state", 64'(dut_st), 64'(exp_st));
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
      if (mon_sz > 0) begin
        chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        chk("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_inst_nop", 64'(out_inst), 64'(NOP));
        chk("out_pc_hold", 64'(out_pc), 64'(exp_last_pc));
      end
    end
  end

  task automatic expect_now(input string name, input logic [63:0] act, input logic [63:0] exp);
    @(negedge clk);
    #1;
    chk(name, act, exp);
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'(NOP));
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

    // Streaming
    step(1'b1, 32'h100, 32'h2401_0001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'h2402_0002, 1'b1, 1'b0, 1'b0);
    chk("stream_first", 64'(out_pc), 64'h100);
    step(1'b1, 32'h108, 32'h2403_0003, 1'b1, 1'b0, 1'b0);
    chk("stream_second", 64'(out_pc), 64'h104);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("stream_third", 64'(out_inst), 64'h2403_0003);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-pressure into skid
    step(1'b1, 32'h200, 32'hA000_0200, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'hA000_0204, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd2);
    chk("bp_head", 64'(out_pc), 64'h200);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_now("bp_ready_back", 64'(in_ready), 64'd1);
    chk("bp_second", 64'(out_pc), 64'h204);

    // Flush priority from FULL
    step(1'b1, 32'h208, 32'hA000_0208, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h300, 32'hDEAD_0300, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_now("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_inst", 64'(out_inst), 64'(NOP));
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Counter saturation and clear
    step(1'b1, 32'h600, 32'h1111_0600, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_now("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_now("clr_cnt_zero", 64'(stall_cnt), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_now("clr_cnt_one", 64'(stall_cnt), 64'd1);

    // Async reset while FULL
    step(1'b1, 32'h500, 32'h2222_0500, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_inst", 64'(out_inst), 64'(NOP));
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    exp_q.delete();
    exp_cnt = 0;
    exp_last_pc = '0;
    p_push = 1'b0; p_flush = 1'b0; p_clr = 1'b0; p_stall = 1'b0;
    in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    step(1'b1, 32'h400, 32'h2404_0400, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_latency", 64'(out_pc), 64'h400);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           $urandom,
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 63) == 0));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
